// File: rtl/laser_line_scanner.sv
// Ping-pong line buffer feeding the laser modulator.
// One stored line is replayed per mirror facet, after a fixed start delay.
module laser_line_scanner #(
    parameter int PIX_W       = 8,
    parameter int LINE_PIXELS = 640,
    parameter int ADDR_W      = 10,
    parameter int START_DELAY = 64,
    parameter int PIX_DIV     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             in_ready,
    input  logic             facet_sync,
    input  logic             clear_flags,
    output logic             laser_on,
    output logic [PIX_W-1:0] laser_level,
    output logic             underflow,
    output logic             sync_overrun
);
    localparam int LEN_W = ADDR_W + 1;
    localparam int DLY_W = $clog2(START_DELAY + 1);
    localparam int DIV_W = $clog2(PIX_DIV + 1);

    typedef enum logic {W_HUNT, W_FILL} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_SCAN} rstate_t;

    logic [PIX_W-1:0] mem [2][LINE_PIXELS];

    wstate_t              wstate_q, wstate_d;
    rstate_t              rstate_q, rstate_d;
    logic [1:0]           full_q, full_d;
    logic                 wptr_q, wptr_d;
    logic                 rptr_q, rptr_d;
    logic [LEN_W-1:0]     wcnt_q, wcnt_d;
    logic [1:0][LEN_W-1:0] len_q, len_d;
    logic [DLY_W-1:0]     dly_q, dly_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [LEN_W-1:0]     pix_q, pix_d;
    logic [PIX_W-1:0]     rd_data_q;
    logic                 in_ready_q, in_ready_d;
    logic                 laser_on_q, laser_on_d;
    logic [PIX_W-1:0]     level_q, level_d;
    logic                 uflow_q, uflow_d;
    logic                 ovrun_q, ovrun_d;

    logic              xfer, we, re, uflow_set, ovrun_set;
    logic [ADDR_W-1:0] waddr, raddr;

    assign xfer = in_valid & in_ready_q;

    always_comb begin
        wstate_d  = wstate_q;
        rstate_d  = rstate_q;
        full_d    = full_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        wcnt_d    = wcnt_q;
        len_d     = len_q;
        dly_d     = dly_q;
        div_d     = div_q;
        pix_d     = pix_q;
        we        = 1'b0;
        waddr     = '0;
        re        = 1'b0;
        raddr     = '0;
        uflow_set = 1'b0;
        ovrun_set = 1'b0;

        if (xfer) begin
            if (in_sop) begin
                we       = 1'b1;
                wcnt_d   = LEN_W'(1);
                wstate_d = W_FILL;
            end else if (wstate_q == W_FILL && wcnt_q < LEN_W'(LINE_PIXELS)) begin
                we     = 1'b1;
                waddr  = wcnt_q[ADDR_W-1:0];
                wcnt_d = wcnt_q + LEN_W'(1);
            end
            // eop without a line in progress is just a dropped pixel
            if (in_eop && (in_sop || wstate_q == W_FILL)) begin
                len_d[wptr_q]  = wcnt_d;
                full_d[wptr_q] = 1'b1;
                wptr_d         = ~wptr_q;
                wstate_d       = W_HUNT;
            end
        end

        case (rstate_q)
            R_IDLE: begin
                if (facet_sync) begin
                    if (full_q[rptr_q]) begin
                        rstate_d = R_DELAY;
                        dly_d    = '0;
                    end else begin
                        uflow_set = 1'b1;
                    end
                end
            end
            R_DELAY: begin
                ovrun_set = facet_sync;
                if (dly_q == DLY_W'(START_DELAY - 1)) begin
                    rstate_d = R_SCAN;
                    pix_d    = '0;
                    div_d    = '0;
                    re       = 1'b1;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            R_SCAN: begin
                ovrun_set = facet_sync;
                if (div_q == DIV_W'(PIX_DIV - 1)) begin
                    div_d = '0;
                    if (pix_q == LEN_W'(LINE_PIXELS - 1)) begin
                        rstate_d       = R_IDLE;
                        full_d[rptr_q] = 1'b0;
                        rptr_d         = ~rptr_q;
                    end else begin
                        pix_d = pix_q + LEN_W'(1);
                        re    = 1'b1;
                        raddr = pix_d[ADDR_W-1:0];
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: rstate_d = R_IDLE;
        endcase

        // outputs are registered one clock after the state that drives them
        laser_on_d = (rstate_q == R_SCAN);
        level_d    = (rstate_q == R_SCAN && pix_q < len_q[rptr_q]) ? rd_data_q : '0;
        in_ready_d = (wstate_d == W_FILL) || !full_d[wptr_d];
        uflow_d    = uflow_set | (uflow_q & ~clear_flags);
        ovrun_d    = ovrun_set | (ovrun_q & ~clear_flags);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wstate_q   <= W_HUNT;
            rstate_q   <= R_IDLE;
            full_q     <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            wcnt_q     <= '0;
            len_q      <= '0;
            dly_q      <= '0;
            div_q      <= '0;
            pix_q      <= '0;
            in_ready_q <= 1'b0;
            laser_on_q <= 1'b0;
            level_q    <= '0;
            uflow_q    <= 1'b0;
            ovrun_q    <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            full_q     <= full_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            wcnt_q     <= wcnt_d;
            len_q      <= len_d;
            dly_q      <= dly_d;
            div_q      <= div_d;
            pix_q      <= pix_d;
            in_ready_q <= in_ready_d;
            laser_on_q <= laser_on_d;
            level_q    <= level_d;
            uflow_q    <= uflow_d;
            ovrun_q    <= ovrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wptr_q][waddr] <= in_data;
        if (re) rd_data_q <= mem[rptr_q][raddr];
    end

    assign in_ready     = in_ready_q;
    assign laser_on     = laser_on_q;
    assign laser_level  = level_q;
    assign underflow    = uflow_q;
    assign sync_overrun = ovrun_q;
endmodule

// File: tb/tb_laser_line_scanner.sv
// Directed bench for laser_line_scanner.
// Lines pushed to a scoreboard queue when written, popped and checked on replay.
module tb_laser_line_scanner;
    localparam int LP   = 640;
    localparam int SD   = 64;
    localparam int PD   = 4;
    localparam int LAST = SD + LP * PD;

    typedef logic [7:0] line_t [LP];

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid, in_sop, in_eop, in_ready;
    logic       facet_sync, clear_flags;
    logic       laser_on, underflow, sync_overrun;
    logic [7:0] laser_level;

    line_t lines_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    laser_line_scanner dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid),
        .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
        .facet_sync(facet_sync), .clear_flags(clear_flags),
        .laser_on(laser_on), .laser_level(laser_level),
        .underflow(underflow), .sync_overrun(sync_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int mode, input int k);
        case (mode)
            0: return 8'(k);
            1: return 8'(3 * k + 7);
            2: return 8'(k) ^ 8'h5A;
            3: return 8'(k + 100);
            4: return 8'(200 - k);
            default: return ~8'(k);
        endcase
    endfunction

    task automatic send_line(input int mode, input int len);
        line_t ln;
        int    w;
        for (int k = 0; k < LP; k++) ln[k] = (k < len) ? pat(mode, k) : 8'h00;
        for (int k = 0; k < len; k++) begin
            in_valid = 1'b1;
            in_data  = pat(mode, k);
            in_sop   = (k == 0);
            in_eop   = (k == len - 1);
            w = 0;
            while (in_ready !== 1'b1 && w < 4000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 4000) begin
                chk("in_ready_wait", 32'(in_ready), 1);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        lines_q.push_back(ln);
    endtask

    task automatic scan(input int ovr_at, input bit stall);
        line_t      ln;
        logic       exp_on;
        logic [7:0] exp_lv;
        ln = lines_q.pop_front();
        facet_sync = 1'b1;
        @(negedge clk);
        facet_sync = 1'b0;
        for (int n = 0; n <= LAST + 6; n++) begin
            if (n > 0) @(negedge clk);
            exp_on = (n >= SD + 1 && n <= LAST);
            exp_lv = 8'h00;
            if (exp_on) exp_lv = ln[(n - SD - 1) / PD];
            chk("laser_on", 32'(laser_on), 32'(exp_on));
            chk("laser_level", 32'(laser_level), 32'(exp_lv));
            if (ovr_at >= 0 && n == ovr_at + 2)
                chk("sync_overrun_set", 32'(sync_overrun), 1);
            if (stall && n <= LAST - 4)
                chk("in_ready_stalled", 32'(in_ready), 0);
            if (stall && n == LAST + 1)
                chk("in_ready_freed", 32'(in_ready), 1);
            facet_sync = (n == ovr_at);
        end
        facet_sync = 1'b0;
        chk("underflow_after_scan", 32'(underflow), 0);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0;
        in_sop = 1'b0; in_eop = 1'b0; facet_sync = 1'b0; clear_flags = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_laser_on", 32'(laser_on), 0);
        chk("rst_laser_level", 32'(laser_level), 0);
        chk("rst_underflow", 32'(underflow), 0);
        chk("rst_sync_overrun", 32'(sync_overrun), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 1);

        // facet with no line loaded
        facet_sync = 1'b1;
        @(negedge clk);
        facet_sync = 1'b0;
        chk("underflow_set", 32'(underflow), 1);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            chk("laser_off_underflow", 32'(laser_on), 0);
        end
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("underflow_cleared", 32'(underflow), 0);
        facet_sync = 1'b1; clear_flags = 1'b1;
        @(negedge clk);
        facet_sync = 1'b0; clear_flags = 1'b0;
        chk("set_beats_clear", 32'(underflow), 1);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("underflow_cleared2", 32'(underflow), 0);

        // full line, then short line
        send_line(0, LP);
        scan(-1, 1'b0);
        send_line(1, 100);
        scan(-1, 1'b0);

        // both banks fill, writer stalls until a scan frees one
        send_line(2, LP);
        send_line(3, LP);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("in_ready_both_full", 32'(in_ready), 0);
        end
        scan(-1, 1'b1);
        send_line(4, LP);

        // facet during scan
        chk("overrun_idle", 32'(sync_overrun), 0);
        scan(1000, 1'b0);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("overrun_cleared", 32'(sync_overrun), 0);

        // reset mid-scan with both banks full
        send_line(5, 50);
        @(negedge clk);
        chk("in_ready_full2", 32'(in_ready), 0);
        facet_sync = 1'b1;
        @(negedge clk);
        facet_sync = 1'b0;
        repeat (500) @(negedge clk);
        chk("midscan_on", 32'(laser_on), 1);
        chk("midscan_level", 32'(laser_level), 32'(lines_q[0][(500 - SD - 1) / PD]));
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        lines_q.delete();
        chk("reset_laser_on", 32'(laser_on), 0);
        chk("reset_laser_level", 32'(laser_level), 0);
        chk("reset_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        chk("ready_after_reset2", 32'(in_ready), 1);
        facet_sync = 1'b1;
        @(negedge clk);
        facet_sync = 1'b0;
        chk("underflow_after_reset", 32'(underflow), 1);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            chk("laser_off_after_reset", 32'(laser_on), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
